// File: rtl/irom_fetch_ctrl.sv
// Instruction-fetch sequencer in front of a synchronous instruction ROM.
// Owns the PC, issues ROM reads and queues returned words for decode.
module irom_fetch_ctrl #(
    parameter int                 DWIDTH   = 16,
    parameter int                 AWIDTH   = 16,
    parameter logic [AWIDTH-1:0]  RESET_PC = '0,
    parameter logic [AWIDTH-1:0]  PC_STEP  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [AWIDTH-1:0] rom_addr,
    output logic              rom_req,
    input  logic [DWIDTH-1:0] rom_dout,
    input  logic              rom_valid,
    input  logic              redir_valid,
    input  logic [AWIDTH-1:0] redir_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DWIDTH-1:0] inst_data,
    output logic [AWIDTH-1:0] inst_pc,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [AWIDTH-1:0] pc;
    logic [AWIDTH-1:0] req_pc;
    logic              inflight;
    logic              squash;

    logic [DWIDTH-1:0] q_data [2];
    logic [AWIDTH-1:0] q_pc   [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;

    logic              redirect;
    logic              issue;
    logic              push;
    logic              pop;
    logic [2:0]        credit;

    // Handshake, credit and issue decisions for the current cycle.
    // A word leaving the queue this cycle frees its slot for the next
    // request, which is what sustains one instruction per cycle.
    always_comb begin
        redirect = redir_valid && (state != IDLE);
        pop      = inst_valid && inst_ready;
        credit   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        issue    = (state == RUN) && !redir_valid && (credit < 3'd2);
        push     = rom_valid && inflight && !squash;
    end

    assign rom_addr   = pc;
    assign rom_req    = issue;
    assign inst_valid = (count != 2'd0);
    assign inst_data  = q_data[rd_ptr];
    assign inst_pc    = q_pc[rd_ptr];
    assign busy       = (state == RUN) || (state == DRAIN);

    // Run-control state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (run) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The one outstanding response lands this cycle.
                    if (run) begin
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Program counter: redirect target or sequential advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redir_valid) begin
            pc <= redir_pc;
        end else if (issue) begin
            pc <= pc + PC_STEP;
        end
    end

    // Outstanding-request tracking and redirect squash.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            squash   <= 1'b0;
            req_pc   <= '0;
        end else begin
            inflight <= issue;
            squash   <= redirect && inflight;
            if (issue) begin
                req_pc <= pc;
            end
        end
    end

    // Two-entry instruction queue; a redirect empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_data[0] <= '0;
            q_data[1] <= '0;
            q_pc[0]   <= '0;
            q_pc[1]   <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
        end else if (redirect) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                q_data[wr_ptr] <= rom_dout;
                q_pc[wr_ptr]   <= req_pc;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_irom_fetch_ctrl.sv
// Directed bench for irom_fetch_ctrl: cycle table plus reset and
// wrap-around sequences, each DUT fed by a one-cycle-latency ROM model.
module tb_irom_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [15:0] rom_addr;
    logic        rom_req;
    logic [15:0] rom_dout = '0;
    logic        rom_valid = 1'b0;
    logic        redir_valid = 1'b0;
    logic [15:0] redir_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [15:0] inst_data;
    logic [15:0] inst_pc;
    logic        busy;

    logic        run1 = 1'b0;
    logic [15:0] rom_addr1;
    logic        rom_req1;
    logic [15:0] rom_dout1 = '0;
    logic        rom_valid1 = 1'b0;
    logic        redir_valid1 = 1'b0;
    logic [15:0] redir_pc1 = '0;
    logic        inst_valid1;
    logic        inst_ready1 = 1'b1;
    logic [15:0] inst_data1;
    logic [15:0] inst_pc1;
    logic        busy1;

    int pass_cnt = 0;
    int total    = 0;

    irom_fetch_ctrl u0 (
        .clk(clk), .rst(rst), .run(run),
        .rom_addr(rom_addr), .rom_req(rom_req),
        .rom_dout(rom_dout), .rom_valid(rom_valid),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc), .busy(busy)
    );

    irom_fetch_ctrl #(.RESET_PC(16'hFFFE)) u1 (
        .clk(clk), .rst(rst), .run(run1),
        .rom_addr(rom_addr1), .rom_req(rom_req1),
        .rom_dout(rom_dout1), .rom_valid(rom_valid1),
        .redir_valid(redir_valid1), .redir_pc(redir_pc1),
        .inst_valid(inst_valid1), .inst_ready(inst_ready1),
        .inst_data(inst_data1), .inst_pc(inst_pc1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // ROM models: ROM[i] = 0xA000 + i, answered the cycle after the request.
    always @(posedge clk) begin
        rom_valid  <= rom_req;
        rom_dout   <= 16'hA000 + rom_addr;
        rom_valid1 <= rom_req1;
        rom_dout1  <= 16'hA000 + rom_addr1;
    end

    typedef struct {
        logic        rst;
        logic        run;
        logic        rdy;
        logic        rv;
        logic [15:0] rpc;
        logic        chk;
        logic        req;
        logic [15:0] addr;
        logic        iv;
        logic [15:0] ipc;
        logic [15:0] idata;
        logic        busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic run_i, input logic rdy_i,
                               input logic rv_i, input logic [15:0] rpc_i,
                               input logic req_i, input logic [15:0] addr_i,
                               input logic iv_i, input logic [15:0] ipc_i,
                               input logic busy_i);
        vec_t r;
        r.rst   = 1'b0;
        r.run   = run_i;
        r.rdy   = rdy_i;
        r.rv    = rv_i;
        r.rpc   = rpc_i;
        r.chk   = 1'b1;
        r.req   = req_i;
        r.addr  = addr_i;
        r.iv    = iv_i;
        r.ipc   = ipc_i;
        r.idata = 16'hA000 + ipc_i;
        r.busy  = busy_i;
        return r;
    endfunction

    function automatic vec_t vrst();
        vec_t r;
        r = v(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
        r.rst = 1'b1;
        r.chk = 1'b0;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [15:0] wexp [4];
    logic [15:0] wdat;
    int          got;

    initial begin
        // Sequential stream, then reset with a request outstanding
        tbl.push_back(v(1, 1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 0));
        tbl.push_back(v(1, 1, 0, 16'h0, 1, 16'h0000, 0, 16'h0000, 1));
        tbl.push_back(v(1, 1, 0, 16'h0, 1, 16'h0001, 0, 16'h0000, 1));
        tbl.push_back(v(1, 1, 0, 16'h0, 1, 16'h0002, 1, 16'h0000, 1));
        tbl.push_back(v(1, 1, 0, 16'h0, 1, 16'h0003, 1, 16'h0001, 1));
        tbl.push_back(v(1, 1, 0, 16'h0, 1, 16'h0004, 1, 16'h0002, 1));
        tbl.push_back(vrst());
        // Backpressure: five stalled cycles after the first word
        tbl.push_back(v(1, 1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 0));
        tbl.push_back(v(1, 1, 0, 16'h0, 1, 16'h0000, 0, 16'h0000, 1));
        tbl.push_back(v(1, 1, 0, 16'h0, 1, 16'h0001, 0, 16'h0000, 1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(1, 0, 0, 16'h0, 0, 16'h0002, 1, 16'h0000, 1));
        tbl.push_back(v(1, 1, 0, 16'h0, 1, 16'h0002, 1, 16'h0000, 1));
        tbl.push_back(v(1, 1, 0, 16'h0, 1, 16'h0003, 1, 16'h0001, 1));
        tbl.push_back(v(1, 1, 0, 16'h0, 1, 16'h0004, 1, 16'h0002, 1));
        // Redirect with one queued word and one in flight
        tbl.push_back(v(1, 1, 1, 16'h0040, 0, 16'h0005, 1, 16'h0003, 1));
        tbl.push_back(v(1, 1, 0, 16'h0, 1, 16'h0040, 0, 16'h0000, 1));
        tbl.push_back(v(1, 1, 0, 16'h0, 1, 16'h0041, 0, 16'h0000, 1));
        tbl.push_back(v(1, 1, 0, 16'h0, 1, 16'h0042, 1, 16'h0040, 1));
        tbl.push_back(v(1, 1, 0, 16'h0, 1, 16'h0043, 1, 16'h0041, 1));
        // Run drop through DRAIN, then resume
        tbl.push_back(v(0, 1, 0, 16'h0, 1, 16'h0044, 1, 16'h0042, 1));
        tbl.push_back(v(0, 1, 0, 16'h0, 0, 16'h0045, 1, 16'h0043, 1));
        tbl.push_back(v(0, 1, 0, 16'h0, 0, 16'h0045, 1, 16'h0044, 0));
        tbl.push_back(v(0, 1, 0, 16'h0, 0, 16'h0045, 0, 16'h0000, 0));
        tbl.push_back(v(1, 1, 0, 16'h0, 0, 16'h0045, 0, 16'h0000, 0));
        tbl.push_back(v(1, 1, 0, 16'h0, 1, 16'h0045, 0, 16'h0000, 1));
        tbl.push_back(v(1, 1, 0, 16'h0, 1, 16'h0046, 0, 16'h0000, 1));
        tbl.push_back(v(1, 1, 0, 16'h0, 1, 16'h0047, 1, 16'h0045, 1));

        wexp[0] = 16'hFFFE;
        wexp[1] = 16'hFFFF;
        wexp[2] = 16'h0000;
        wexp[3] = 16'h0001;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_data", {16'h0, inst_data}, 32'h0);
        check("rst_pc", {16'h0, inst_pc}, 32'h0);
        check("rst_addr_u1", {16'h0, rom_addr1}, 32'hFFFE);
        check("rst_busy_u1", {31'h0, busy1}, 32'h0);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst         = tbl[i].rst;
            run         = tbl[i].run;
            inst_ready  = tbl[i].rdy;
            redir_valid = tbl[i].rv;
            redir_pc    = tbl[i].rpc;
            #1;
            if (tbl[i].chk) begin
                check($sformatf("r%0d_req", i), {31'h0, rom_req},
                      {31'h0, tbl[i].req});
                check($sformatf("r%0d_addr", i), {16'h0, rom_addr},
                      {16'h0, tbl[i].addr});
                check($sformatf("r%0d_valid", i), {31'h0, inst_valid},
                      {31'h0, tbl[i].iv});
                check($sformatf("r%0d_busy", i), {31'h0, busy},
                      {31'h0, tbl[i].busy});
                if (tbl[i].iv) begin
                    check($sformatf("r%0d_pc", i), {16'h0, inst_pc},
                          {16'h0, tbl[i].ipc});
                    check($sformatf("r%0d_data", i), {16'h0, inst_data},
                          {16'h0, tbl[i].idata});
                end
            end
        end

        // Fill the queue, then reset while a new request goes out
        @(negedge clk);
        redir_valid = 1'b0;
        inst_ready  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("full_valid", {31'h0, inst_valid}, 32'h1);
        check("full_req", {31'h0, rom_req}, 32'h0);
        check("full_head", {16'h0, inst_pc}, 32'h46);
        @(negedge clk);
        rst        = 1'b1;
        inst_ready = 1'b1;
        #1;
        check("rstcyc_req", {31'h0, rom_req}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        #1;
        check("prst_valid", {31'h0, inst_valid}, 32'h0);
        check("prst_addr", {16'h0, rom_addr}, 32'h0);
        check("prst_busy", {31'h0, busy}, 32'h0);
        check("prst_data", {16'h0, inst_data}, 32'h0);
        check("prst_late_rsp", {31'h0, rom_valid}, 32'h1);
        @(negedge clk);
        #1;
        check("prst_valid2", {31'h0, inst_valid}, 32'h0);

        // PC wrap on the instance reset to 0xFFFE
        @(negedge clk);
        run1 = 1'b1;
        got  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (inst_valid1 && got < 4) begin
                wdat = 16'hA000 + wexp[got];
                check($sformatf("wrap%0d_pc", got), {16'h0, inst_pc1},
                      {16'h0, wexp[got]});
                check($sformatf("wrap%0d_data", got), {16'h0, inst_data1},
                      {16'h0, wdat});
                got++;
            end
        end
        check("wrap_count", got, 4);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
